pmux_rr_arbiter: RTL and testbench
==================================

Name: pmux_rr_arbiter

Overview:
- Shares one 16-bit output channel among 8 requesters using round-robin priority.
- Internally selects one of eight data inputs with a 3-bit select, as an 8:1 case-mux datapath does, and registers the winner into a single-entry output stage.
- The output stage uses a valid/ready handshake.
- Sits between eight producer ports and one downstream consumer. Acts as the sequencing/arbitration layer that drives the select of the shared 8:1 mux.

Parameters:
- WIDTH, 16, data width of each requester input and of q_o.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- req_i  input  8  request per requester; bit k belongs to data_k_i.
- data_0_i .. data_7_i  input  WIDTH each  requester payloads; valid whenever the matching req_i bit is high.
- gnt_o  output  8  one-hot grant; combinational; high only in the cycle the payload is accepted.
- valid_o  output  1  q_o holds an unconsumed word.
- ready_i  input  1  downstream accepts q_o this cycle when valid_o is also high.
- q_o  output  WIDTH  registered payload of the last granted requester.
- sel_o  output  3  registered index of the requester that produced q_o.

Behaviour:
- Reset (rst_i high at a clock edge) forces: valid_o=0, q_o=0, sel_o=0, priority pointer ptr=0.
  - gnt_o=0 in every cycle rst_i is high.
  - A word pending mid-operation is discarded; no grant is issued in that cycle.
- Internal state:
  - ptr, 3 bits: highest-priority index.
  - Output register: q_o, sel_o, valid_o.
- FSM has two states:
  - EMPTY (valid_o=0).
  - FULL (valid_o=1).
- Definitions:
  - drain = valid_o & ready_i.
  - space = ~valid_o | drain.
  - accept = space & (req_i != 0) & ~rst_i.
- Winner selection: w is the first set bit of req_i scanning ptr, ptr+1, ... ptr+7, modulo 8. Example: ptr=6 scans 6, 7, 0, 1, ...
- On accept:
  - gnt_o = one-hot(w) in that cycle.
  - Next edge: q_o<=data_w_i, sel_o<=w, valid_o<=1, ptr<=(w+1) mod 8. ptr wraps 7 -> 0.
- On drain without accept: valid_o<=0; q_o and sel_o hold.
- When FULL and ready_i=0:
  - No grant is issued.
  - q_o, sel_o, valid_o hold stable.
  - req_i may change freely.
- Simultaneous drain and accept: the new word replaces the old in the same edge; valid_o stays 1. This gives full throughput of one word per cycle.
- Latency: grant cycle N -> valid_o=1 with data at cycle N+1.
- ptr changes only on accept. Requests that drop without a grant have no effect.
- Fairness: a requester holding req_i high is granted within at most 8 accepts.
- gnt_o is at most one-hot; gnt_o=0 whenever accept=0.
- All widths are exact; no arithmetic beyond the 3-bit modulo-8 increment.

Test Plan:
- Reset, then req_i=0 for 5 cycles -> valid_o=0, gnt_o=0, q_o=0, sel_o=0 throughout.
- ready_i=1, req_i=8'hFF, data_k_i=16'h1000+k for 10 cycles -> gnt_o sequence 0x01,0x02,...,0x80,0x01,0x02. q_o one cycle later: 0x1000..0x1007,0x1000,0x1001; valid_o continuously 1.
- Backpressure: single request req_i=8'h04, data_2_i=16'hBEEF, ready_i=0 -> one grant, valid_o=1, q_o=0xBEEF. Then gnt_o=0 while ready_i=0 for 4 cycles with q_o stable. Raise ready_i -> valid_o drops next cycle if req_i=0.
- Wrap/priority: after a grant to 7 (ptr=0), req_i=8'h81 -> grant 0 first, then 7. After a grant to 5 (ptr=6), req_i=8'h21 -> grant 0 (scan 6, 7, 0) before 5.
- Simultaneous drain and accept: FULL with ready_i=1 and req_i=8'h10, data_4_i=16'h0044 -> gnt_o=0x10 same cycle. Next edge q_o=0x0044, sel_o=4, valid_o stays 1.
- Reset mid-operation: FULL with q_o=0x1234, sel_o=3, assert rst_i for 1 cycle with req_i=8'hFF -> gnt_o=0 that cycle; next edge valid_o=0, q_o=0, sel_o=0. First grant after release goes to requester 0.

Source files
------------

// File: rtl/pmux_rr_arbiter.sv
// pmux_rr_arbiter: round-robin arbiter driving an 8:1 payload mux into a valid/ready output register
module pmux_rr_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       req_i,
  input  logic [WIDTH-1:0] data_0_i,
  input  logic [WIDTH-1:0] data_1_i,
  input  logic [WIDTH-1:0] data_2_i,
  input  logic [WIDTH-1:0] data_3_i,
  input  logic [WIDTH-1:0] data_4_i,
  input  logic [WIDTH-1:0] data_5_i,
  input  logic [WIDTH-1:0] data_6_i,
  input  logic [WIDTH-1:0] data_7_i,
  output logic [7:0]       gnt_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] q_o,
  output logic [2:0]       sel_o
);
  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;
  logic             state;
  logic [2:0]       ptr;
  logic [15:0]      req2;
  logic [7:0]       rot;
  logic [2:0]       off;
  logic [2:0]       w;
  logic [WIDTH-1:0] win_data;
  logic             drain;
  logic             space;
  logic             accept;
  assign valid_o = state == FULL;
  assign drain   = valid_o & ready_i;
  assign space   = ~valid_o | drain;
  assign accept  = space & (req_i != 8'd0) & ~rst_i;
  assign req2    = {req_i, req_i} >> ptr;
  assign rot     = req2[7:0];
  assign w       = ptr + off;
  assign gnt_o   = accept ? 8'd1 << w : 8'd0;
  // first set bit of the request vector rotated so ptr sits at bit 0
  always_comb begin
    off = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (rot[i]) off = 3'(i);
  end
  // shared 8:1 payload mux steered by the winner index
  always_comb begin
    case (w)
      3'd0:    win_data = data_0_i;
      3'd1:    win_data = data_1_i;
      3'd2:    win_data = data_2_i;
      3'd3:    win_data = data_3_i;
      3'd4:    win_data = data_4_i;
      3'd5:    win_data = data_5_i;
      3'd6:    win_data = data_6_i;
      default: win_data = data_7_i;
    endcase
  end
  // output stage and priority pointer; accept wins over drain so both in one cycle keeps FULL
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= EMPTY;
      q_o   <= '0;
      sel_o <= 3'd0;
      ptr   <= 3'd0;
    end else if (accept) begin
      state <= FULL;
      q_o   <= win_data;
      sel_o <= w;
      ptr   <= w + 3'd1;
    end else if (drain) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_pmux_rr_arbiter.sv
// tb_pmux_rr_arbiter: directed checks of grant order, handshake and reset for pmux_rr_arbiter
module tb_pmux_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req;
  logic        ready;
  logic [15:0] d [8];
  logic [7:0]  gnt;
  logic        valid;
  logic [15:0] q;
  logic [2:0]  sel;
  int          checks = 0;
  int          errors = 0;

  pmux_rr_arbiter #(.WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .data_0_i(d[0]), .data_1_i(d[1]), .data_2_i(d[2]), .data_3_i(d[3]),
    .data_4_i(d[4]), .data_5_i(d[5]), .data_6_i(d[6]), .data_7_i(d[7]),
    .gnt_o(gnt), .valid_o(valid), .ready_i(ready), .q_o(q), .sel_o(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] eq, input logic [2:0] es);
    chk({tag, "_valid"}, 32'(valid), 32'(v));
    chk({tag, "_q"}, 32'(q), 32'(eq));
    chk({tag, "_sel"}, 32'(sel), 32'(es));
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; ready = 1'b0;
    for (int k = 0; k < 8; k++) d[k] = 16'h1000 + 16'(k);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    tick();
    chk_out("rst", 1'b0, 16'h0, 3'd0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("idle_gnt", 32'(gnt), 32'h0);
      tick();
      chk_out("idle", 1'b0, 16'h0, 3'd0);
    end
    ready = 1'b1; req = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("rr_gnt", 32'(gnt), 32'(8'h01 << (i % 8)));
      tick();
      chk_out("rr", 1'b1, 16'h1000 + 16'(i % 8), 3'(i % 8));
    end
    req = 8'h00;
    #1;
    chk("drain_gnt", 32'(gnt), 32'h0);
    tick();
    chk_out("drain", 1'b0, 16'h1001, 3'd1);
    ready = 1'b0; req = 8'h04; d[2] = 16'hBEEF;
    #1;
    chk("bp_gnt", 32'(gnt), 32'h04);
    tick();
    chk_out("bp_load", 1'b1, 16'hBEEF, 3'd2);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_hold_gnt", 32'(gnt), 32'h0);
      tick();
      chk_out("bp_hold", 1'b1, 16'hBEEF, 3'd2);
    end
    ready = 1'b1; req = 8'h00;
    #1;
    chk("bp_rel_gnt", 32'(gnt), 32'h0);
    tick();
    chk_out("bp_rel", 1'b0, 16'hBEEF, 3'd2);
    d[2] = 16'h1002;
    req = 8'h80;
    #1;
    chk("g7_gnt", 32'(gnt), 32'h80);
    tick();
    chk_out("g7", 1'b1, 16'h1007, 3'd7);
    req = 8'h81;
    #1;
    chk("wrap0_gnt", 32'(gnt), 32'h01);
    tick();
    chk_out("wrap0", 1'b1, 16'h1000, 3'd0);
    #1;
    chk("wrap7_gnt", 32'(gnt), 32'h80);
    tick();
    chk_out("wrap7", 1'b1, 16'h1007, 3'd7);
    req = 8'h20;
    #1;
    chk("g5_gnt", 32'(gnt), 32'h20);
    tick();
    chk_out("g5", 1'b1, 16'h1005, 3'd5);
    req = 8'h21;
    #1;
    chk("scan0_gnt", 32'(gnt), 32'h01);
    tick();
    chk_out("scan0", 1'b1, 16'h1000, 3'd0);
    #1;
    chk("scan5_gnt", 32'(gnt), 32'h20);
    tick();
    chk_out("scan5", 1'b1, 16'h1005, 3'd5);
    req = 8'h10; d[4] = 16'h0044;
    #1;
    chk("sim_gnt", 32'(gnt), 32'h10);
    tick();
    chk_out("sim", 1'b1, 16'h0044, 3'd4);
    req = 8'h08; d[3] = 16'h1234;
    #1;
    chk("pre_rst_gnt", 32'(gnt), 32'h08);
    tick();
    chk_out("pre_rst", 1'b1, 16'h1234, 3'd3);
    rst = 1'b1; req = 8'hFF;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    tick();
    chk_out("mid_rst", 1'b0, 16'h0, 3'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'h01);
    tick();
    chk_out("post_rst", 1'b1, 16'h1000, 3'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
